// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter run controller: start/stop/hold sequencing of an
// N-stage Johnson register with round counting and one-hot phase strobes.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start, stop      run request / abort request (stop has priority)
//   hold             freeze stepping while running
//   rounds [RW]      bounded round count, 0 = continuous (latched on start)
//   cnt [N]          Johnson register
//   phase [2N]       one-hot decode of cnt
//   busy             high while running
//   wrap             pulse after cnt returns from the last phase to phase 0
//   done             pulse on bounded-run completion
//   round_cnt [RW]   completed rounds of the current or last run
//   err              sticky, start seen while running
module johnson_seq_ctrl #(
  parameter int N  = 4,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic [RW-1:0] rounds,
  output logic [N-1:0]  cnt,
  output logic [2*N-1:0] phase,
  output logic          busy,
  output logic          wrap,
  output logic          done,
  output logic [RW-1:0] round_cnt,
  output logic          err
);

  localparam int PH = 2 * N;
  localparam int IW = $clog2(PH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [RW-1:0] lim_q, lim_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [N-1:0]  cnt_step;
  logic [RW-1:0] rcnt_inc;
  logic          at_last;
  logic          accept;

  assign cnt_step = {cnt_q[N-2:0], ~cnt_q[N-1]};
  assign rcnt_inc = rcnt_q + RW'(1);
  // Last phase is the lone MSB pattern (1000 for N=4).
  assign at_last  = cnt_q[N-1] & ~(|cnt_q[N-2:0]);
  // A start is honoured from IDLE and from the one-cycle DONE state.
  assign accept   = start & ~stop &
                    ((state_q == S_IDLE) | (state_q == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      lim_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      lim_q   <= lim_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    lim_d   = lim_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (start) err_d = 1'b1;
          if (!hold) begin
            cnt_d = cnt_step;
            if (at_last) begin
              rcnt_d = rcnt_inc;
              wrap_d = 1'b1;
              if (lim_q != '0 && rcnt_inc == lim_q)
                state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      state_d = S_RUN;
      cnt_d   = '0;
      rcnt_d  = '0;
      lim_d   = rounds;
    end
  end

  // Output logic
  logic [IW-1:0] ones;
  logic [IW-1:0] idx;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++)
      ones = ones + IW'(cnt_q[i]);
    // Rising half: index = number of ones.
    // Falling half (MSB set): index = 2N - number of ones.
    idx   = cnt_q[N-1] ? (IW'(PH) - ones) : ones;
    phase = PH'(1) << idx;
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

  assign cnt       = cnt_q;
  assign wrap      = wrap_q;
  assign round_cnt = rcnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios then random
// stimulus, all checked against a phase-index reference model.
module tb_johnson_seq_ctrl;
  localparam int N  = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, hold;
  logic [RW-1:0] rounds;
  logic [N-1:0]  cnt;
  logic [2*N-1:0] phase;
  logic          busy, wrap, done, err;
  logic [RW-1:0] round_cnt;

  int checks = 0;
  int errors = 0;

  // model: st 0=idle 1=run 2=done, k = phase index
  int m_st, m_k, m_rc, m_lim;
  bit m_wrap, m_err;

  int n_busy, n_ph3, w1, w2, d_at;

  johnson_seq_ctrl #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .hold(hold), .rounds(rounds), .cnt(cnt), .phase(phase),
    .busy(busy), .wrap(wrap), .done(done),
    .round_cnt(round_cnt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int pat(input int k);
    int full;
    full = (1 << N) - 1;
    if (k < N) return (1 << k) - 1;
    return (full << (k - N)) & full;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit p,
                       input bit h, input int rnd);
    m_wrap = 0;
    if (r) begin
      m_st = 0; m_k = 0; m_rc = 0; m_lim = 0; m_err = 0;
    end else if (m_st == 1) begin
      if (p) begin
        m_st = 0; m_k = 0;
      end else begin
        if (s) m_err = 1;
        if (!h) begin
          if (m_k == 2*N-1) begin
            m_k = 0;
            m_rc = (m_rc + 1) % (1 << RW);
            m_wrap = 1;
            if (m_lim != 0 && m_rc == m_lim) m_st = 2;
          end else begin
            m_k++;
          end
        end
      end
    end else begin
      m_st = 0; m_k = 0;
      if (s && !p) begin
        m_st = 1; m_rc = 0; m_lim = rnd;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt", 32'(cnt), 32'(pat(m_k)));
    chk("phase", 32'(phase), 32'(1 << m_k));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("round_cnt", 32'(round_cnt), 32'(m_rc));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic cyc(input bit r, input bit s, input bit p,
                     input bit h, input int rnd);
    rst = r; start = s; stop = p; hold = h;
    rounds = RW'(rnd);
    @(posedge clk);
    model(r, s, p, h, rnd);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; hold = 0; rounds = '0;
    m_st = 0; m_k = 0; m_rc = 0; m_lim = 0; m_wrap = 0; m_err = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_phase", 32'(phase), 32'h1);
    cyc(0, 0, 0, 0, 0);

    // bounded run of 2 rounds
    n_busy = 0; w1 = -1; w2 = -1; d_at = -1;
    for (int i = 0; i <= 18; i++) begin
      cyc(0, i == 0, 0, 0, 2);
      if (busy) n_busy++;
      if (wrap && w1 < 0) w1 = i;
      else if (wrap) w2 = i;
      if (done) d_at = i;
    end
    chk("t1_busy_cycles", 32'(n_busy), 32'd16);
    chk("t1_wrap1", 32'(w1), 32'd8);
    chk("t1_wrap2", 32'(w2), 32'd16);
    chk("t1_done_at", 32'(d_at), 32'd16);
    chk("t1_rounds", 32'(round_cnt), 32'd2);

    // one round with hold stretching phase 3
    n_ph3 = 0; d_at = -1;
    for (int i = 0; i <= 13; i++) begin
      cyc(0, i == 0, 0, i >= 4 && i <= 6, 1);
      if (phase[3]) n_ph3++;
      if (done) d_at = i;
    end
    chk("t2_phase3_len", 32'(n_ph3), 32'd4);
    chk("t2_done_at", 32'(d_at), 32'd11);

    // continuous, three rounds, then stop
    for (int i = 0; i <= 24; i++) cyc(0, i == 0, 0, 0, 0);
    chk("t3_rounds", 32'(round_cnt), 32'd3);
    cyc(0, 0, 1, 0, 0);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_rc", 32'(round_cnt), 32'd3);
    cyc(0, 0, 0, 0, 0);

    // start mid-run at 0011 sets sticky err
    for (int i = 0; i <= 9; i++) cyc(0, i == 0 || i == 3, 0, 0, 1);
    chk("t4_err", 32'(err), 32'd1);

    // restart from DONE, then start+stop in IDLE
    for (int i = 0; i <= 9; i++) cyc(0, i == 0 || i == 9, 0, 0, 1);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    chk("t5_restart_cnt", 32'(cnt), 32'd0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 1);
    chk("t5_ss_busy", 32'(busy), 32'd0);
    chk("t5_err_sticky", 32'(err), 32'd1);

    // reset mid-run at 1110
    for (int i = 0; i <= 5; i++) cyc(0, i == 0, 0, 0, 0);
    chk("t6_cnt_pre", 32'(cnt), 32'hE);
    cyc(1, 0, 0, 0, 0);
    chk("t6_err_clr", 32'(err), 32'd0);
    chk("t6_wrap", 32'(wrap), 32'd0);
    cyc(0, 0, 0, 0, 0);

    // random stimulus
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 10) == 0,
          ($urandom % 40) == 0, ($urandom % 5) == 0,
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Run controller for a Johnson-counter phase generator. It owns an N-stage Johnson register (2N legal states) and steps it under start/stop/hold control. It counts completed rounds, ends a bounded run with a done pulse, or runs continuously when the round count is 0. It drives one-hot phase strobes that downstream blocks use as time slots, sitting between the system control logic and any slot-sequenced datapath.

## Interface
- N, default 4, number of Johnson stages; 2N phases per round; N >= 2
- RW, default 8, width of the round limit and round counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request, sampled each cycle
- stop  in  1  abort request, sampled each cycle
- hold  in  1  pause stepping while in RUN
- rounds  in  RW  number of rounds to run; 0 = continuous; latched on accepted start
- cnt  out  N  Johnson register value
- phase  out  2N  one-hot decode of cnt
- busy  out  1  high while in RUN
- wrap  out  1  one-cycle pulse; high in the cycle after cnt steps from the last phase back to phase 0
- done  out  1  one-cycle pulse on bounded-run completion
- round_cnt  out  RW  completed rounds in the current or last run
- err  out  1  sticky; start received while busy

## Operation
- Step rule: cnt_next = {cnt[N-2:0], ~cnt[N-1]}. For N=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Phase index k = position in this sequence, starting with 0000 = 0. phase[k] = 1 and all other bits are 0. phase is a combinational decode of cnt.
- States: IDLE, RUN, DONE.
  - IDLE: cnt = 0. On start, go to RUN, clear cnt and round_cnt, and latch rounds into lim.
  - RUN: with hold = 0, cnt steps once per cycle. With hold = 1, cnt, round_cnt and state are frozen.
  - Round completion: cnt steps from phase 2N-1 to 0. In that same edge, round_cnt increments (modulo 2^RW) and wrap is registered high.
  - Bounded end: if lim != 0 and round_cnt+1 == lim at a wrap, go to DONE. cnt = 0 and done = 1 in DONE.
  - Continuous: if lim = 0, never go to DONE; round_cnt wraps modulo 2^RW.
  - DONE lasts exactly one cycle, then goes to IDLE. If start is high in DONE, go straight to RUN (restart), with the start-acceptance actions above.
- Priority, highest first: rst, then stop, then start, then hold.
  - stop in RUN or DONE: go to IDLE and clear cnt. round_cnt holds its value. No done, no wrap.
  - stop together with start in IDLE: stay in IDLE.
  - stop together with hold: stop wins.
- start in RUN is ignored for sequencing and sets err. err clears only on rst.
- round_cnt holds its final value in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, cnt = 0, phase = 1 (bit 0 set), busy = 0, wrap = 0, done = 0, round_cnt = 0, err = 0.
- Start latency: start sampled at edge E0 gives busy = 1 and cnt = 0 in the cycle after E0. The first step occurs at E1.
- Phase k is shown for exactly one cycle per round when hold = 0. hold stretches the current phase one cycle per held cycle.
- Bounded run with hold never asserted:
  - busy is high for lim·2N cycles.
  - done rises in the cycle after edge E(lim·2N) and is high for 1 cycle. busy is 0 in that cycle.
  - wrap is also high in that final cycle.
- All outputs are registered except phase, which decodes registered cnt.

## Test plan
- Reset, then rounds = 2, start pulse with N = 4.
  - cnt runs 0000 through 1000 twice.
  - wrap is high 8 and 16 cycles after the start edge.
  - done is high for one cycle at +16 with round_cnt = 2.
  - busy is high for exactly 16 cycles; err = 0.
- rounds = 1, hold held high for 3 cycles while cnt = 0111.
  - phase[3] stays high for 4 cycles.
  - done occurs at +11 instead of +8.
- rounds = 0 (continuous).
  - Run 3 rounds, wrap pulses every 8 cycles, round_cnt = 3.
  - stop: the next cycle shows IDLE, cnt = 0000, busy = 0, no done, round_cnt stays 3.
- start pulse mid-run at cnt = 0011: sequence unaffected, err goes to 1 and stays 1 through later runs until rst.
- start asserted in the DONE cycle: RUN the next cycle with cnt = 0000 and round_cnt = 0. start + stop together in IDLE: stays IDLE.
- rst asserted mid-run at cnt = 1110: all outputs take their reset values at the next edge, with no wrap or done pulse.
